// File: rtl/rotate_pkg.sv
// Shared definitions for the multi-position rotate engine and the downstream
// single-step rotator stage.
package rotate_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rotate_step.sv
// Purely combinational one-position rotate; left wraps MSB to LSB, right
// wraps LSB to MSB.
module rotate_step
   import rotate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] word,
   input  logic             dir,
   output logic [WIDTH-1:0] rotated
);

   always_comb begin
      rotated = {word[WIDTH-2:0], word[WIDTH-1]};
      if (dir == DIR_RIGHT) begin
         rotated = {word[0], word[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/rotate_sequencer.sv
// Rotates an accepted word one position per clock and holds the result until
// the consumer takes it.
module rotate_sequencer
   import rotate_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             rot_dir,
   input  logic [AMT_W-1:0] rot_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             busy
);

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] step_out;
   logic             dir;
   logic [AMT_W-1:0] count;

   rotate_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .word    (work),
      .dir     (dir),
      .rotated (step_out)
   );

   // Leaving ROTATE at count == 1 captures the final step, so count never wraps.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         work     <= '0;
         dir      <= DIR_LEFT;
         count    <= '0;
         data_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work  <= data_in;
                  dir   <= rot_dir;
                  count <= rot_amt;
                  if (rot_amt == '0) begin
                     data_out <= data_in;
                     state    <= DONE;
                  end else begin
                     state <= ROTATE;
                  end
               end
            end
            ROTATE: begin
               work  <= step_out;
               count <= count - AMT_W'(1);
               if (count == AMT_W'(1)) begin
                  data_out <= step_out;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == ROTATE) || (state == DONE);

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed and randomized checks of rotate_sequencer against hand-computed
// values and a shift-based reference rotate.
module tb_rotate_sequencer;

   localparam int WIDTH = 8;
   localparam int AMT_W = 3;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_in;
   logic             rot_dir;
   logic [AMT_W-1:0] rot_amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   logic             busy;

   int testCount = 0;
   int failCount = 0;

   rotate_sequencer #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .rot_dir   (rot_dir),
      .rot_amt   (rot_amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] rotRef(input logic [WIDTH-1:0] w,
                                               input logic d,
                                               input int amt);
      logic [2*WIDTH-1:0] wide;
      wide = {w, w};
      if (amt == 0) return w;
      if (d == 1'b0) return wide[2*WIDTH-1-amt -: WIDTH];
      return wide[amt +: WIDTH];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one request for a single accept edge, then waits for out_valid.
   task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic dr,
                                input logic [AMT_W-1:0] a, input string tag,
                                output int lat);
      @(negedge clk);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      data_in  = d;
      rot_dir  = dr;
      rot_amt  = a;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic runRequest(input logic [WIDTH-1:0] d, input logic dr,
                             input logic [AMT_W-1:0] a, input logic [WIDTH-1:0] exp,
                             input string tag);
      int lat;
      applyStimulus(d, dr, a, tag, lat);
      checkOutput({tag, "_latency"}, 32'(lat), 32'(a));
      checkOutput({tag, "_data"}, 32'(data_out), 32'(exp));
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({tag, "_valid_clear"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [WIDTH-1:0] expQ[$];
      logic [WIDTH-1:0] expWord;
      int lat;
      int staleSeen;
      int drainCycles;

      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      rot_dir   = 1'b0;
      rot_amt   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_data_out", 32'(data_out), 32'h00);

      runRequest(8'hB4, 1'b0, 3'd3, 8'hA5, "b4_left3");
      runRequest(8'hB4, 1'b1, 3'd3, 8'h96, "b4_right3");
      runRequest(8'h5A, 1'b0, 3'd0, 8'h5A, "5a_amt0");
      runRequest(8'h81, 1'b0, 3'd7, 8'hC0, "81_left7");

      // Backpressure: result must hold while data_in is toggled underneath.
      applyStimulus(8'h01, 1'b1, 3'd1, "bp", lat);
      checkOutput("bp_latency", 32'(lat), 32'd1);
      for (int i = 0; i < 5; i++) begin
         data_in = data_in ^ 8'hFF;
         rot_dir = ~rot_dir;
         @(posedge clk);
         @(negedge clk);
         checkOutput("bp_valid_hold", 32'(out_valid), 32'd1);
         checkOutput("bp_data_hold", 32'(data_out), 32'h80);
         checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("bp_release", 32'(out_valid), 32'd0);

      // Reset two edges into a six-step rotate.
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = 8'h3C;
      rot_dir  = 1'b0;
      rot_amt  = 3'd6;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_data_out", 32'(data_out), 32'h00);
      staleSeen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) staleSeen++;
      end
      out_ready = 1'b0;
      checkOutput("midrst_no_stale", 32'(staleSeen), 32'd0);

      // Random traffic with a queue-based scoreboard.
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 1) == 1);
         data_in   = WIDTH'($urandom);
         rot_dir   = 1'($urandom_range(0, 1));
         rot_amt   = AMT_W'($urandom_range(0, WIDTH - 1));
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         checkOutput("rand_ready_vs_busy", 32'(in_ready && busy), 32'd0);
         if (in_valid && in_ready) begin
            expQ.push_back(rotRef(data_in, rot_dir, int'(rot_amt)));
         end
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("rand_unexpected_result", 32'd1, 32'd0);
            end else begin
               expWord = expQ.pop_front();
               checkOutput("rand_result", 32'(data_out), 32'(expWord));
            end
         end
      end
      @(negedge clk);
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      drainCycles = 0;
      while (expQ.size() != 0 && drainCycles < 40) begin
         #1;
         if (out_valid) begin
            expWord = expQ.pop_front();
            checkOutput("drain_result", 32'(data_out), 32'(expWord));
         end
         @(negedge clk);
         drainCycles++;
      end
      checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/rotate_sequencer.md
# rotate_sequencer

Multi-position rotate engine that sits directly upstream of the single-step bitwise rotator register stage. It accepts a word, a direction and a rotation amount over a valid/ready handshake. It rotates the word one position per clock and presents the result over a second valid/ready handshake. Rotation is performed by an internal one-position rotate step with the same direction encoding as the downstream stage: 0 = left, 1 = right.

## Interface
- WIDTH, 8, data word width; must be a power of two and at least 2
- AMT_W, $clog2(WIDTH), width of the rotation amount field
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- in_valid  input  1  request present on data_in/rot_dir/rot_amt
- in_ready  output  1  block can accept a request; high only in IDLE
- data_in  input  WIDTH  word to rotate
- rot_dir  input  1  0 = rotate left (MSB wraps to LSB), 1 = rotate right (LSB wraps to MSB)
- rot_amt  input  AMT_W  number of positions, 0..WIDTH-1
- out_valid  output  1  result on data_out is valid; high only in DONE
- out_ready  input  1  consumer accepts result
- data_out  output  WIDTH  rotated result (registered)
- busy  output  1  high in ROTATE or DONE

## Operation
- FSM has three states: IDLE, ROTATE and DONE.
- IDLE:
  - On in_valid && in_ready, load work register = data_in, dir register = rot_dir, and count = rot_amt.
  - If rot_amt == 0, go to DONE with data_out = data_in.
  - Otherwise, go to ROTATE.
- ROTATE:
  - Each cycle, work = rotate_step(work, dir) and count decrements by 1.
  - When count == 1, go to DONE with data_out = rotated value.
- DONE:
  - Hold data_out.
  - On out_valid && out_ready, go to IDLE.
  - A result is never dropped or overwritten before it is accepted.
- in_ready = (state == IDLE). There is no accept in DONE, even when out_ready is high; this costs one bubble cycle.
- Inputs are sampled only on the accept edge. Changes to data_in, rot_dir or rot_amt while busy are ignored.
- Rotate arithmetic: left gives {w[WIDTH-2:0], w[WIDTH-1]}; right gives {w[0], w[WIDTH-1:1]}. The count never underflows.
- Reset (reset low at a rising edge) returns the block to IDLE from any state, including mid-ROTATE and DONE. Any in-flight request is discarded.
- Reset values: in_ready = 1, out_valid = 0, busy = 0, data_out = 0. Work, dir and count registers are cleared to 0.
- data_out changes only on entry to DONE, or on reset.

## Timing
- Accept at edge E0. out_valid is first high after edge E0 + rot_amt.
  - rot_amt = 0: valid in the cycle after E0.
  - rot_amt = WIDTH-1: valid after E0 + WIDTH-1.
- Result handshake completes at the edge where out_valid && out_ready. in_ready rises in the following cycle.
- Minimum request spacing is rot_amt + 2 cycles when out_ready is held high.
- Backpressure: out_valid stays high and data_out stays stable for any number of cycles with out_ready low.
- Outputs are driven only by registers or decoded state; there is no combinational path from an input to an output.

## Structure
- Shared package rotate_pkg contains:
  - state enum {IDLE, ROTATE, DONE};
  - direction constants DIR_LEFT = 1'b0 and DIR_RIGHT = 1'b1.
- The downstream rotator stage uses the same rotate_pkg direction constants.
- Sub-module rotate_step: purely combinational single-position rotate with parameter WIDTH and inputs word and dir. It is instantiated once, on the work register.

## Test plan
- Reset low for 2 edges, then high: in_ready = 1, out_valid = 0, busy = 0, data_out = 0x00.
- data_in = 0xB4, rot_dir = 0, rot_amt = 3: out_valid rises 3 edges after accept, data_out = 0xA5. Same word with rot_dir = 1, rot_amt = 3: data_out = 0x96.
- data_in = 0x5A, rot_amt = 0: out_valid in the cycle after accept, data_out = 0x5A. data_in = 0x81, rot_dir = 0, rot_amt = 7: data_out = 0xC0 after 7 edges.
- Backpressure test:
  - Request 0x01, right, 1: gives data_out = 0x80.
  - Hold out_ready low for 5 cycles: out_valid and data_out stay stable and in_ready = 0.
  - Toggle data_in during the stall: no effect on the result.
- Reset low mid-ROTATE (rot_amt = 6, 2 edges in): next cycle shows IDLE, out_valid = 0, data_out = 0x00, and no stale result afterward.
- Back-to-back random requests with random out_ready: every accepted request produces exactly one result, in order, matching a reference rotate model; in_ready is never high while busy.
